fiber_pe_arbiter: RTL and testbench

Request arbiter and response router between the PE crossbar and one `fiberBank`. It merges up to `NUM_PE` PE request streams into the bank's single request port using round-robin arbitration with one register stage. It records the requester of every data-returning request in an in-order ID FIFO. Bank read data is steered back to the PE at the FIFO head.

---
 rtl/fiber_pkg.sv | 20 ++
 rtl/fiber_id_fifo.sv | 61 ++++++
 rtl/fiber_pe_arbiter.sv | 168 ++++++++++++++++
 tb/tb_fiber_pe_arbiter.sv | 367 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fiber_pkg.sv
// Shared request-type encodings and small classification helpers for the
// fiber bank PE arbiter.
package fiber_pkg;

  localparam logic [3:0] FETCH   = 4'b0001;
  localparam logic [3:0] READ    = 4'b0010;
  localparam logic [3:0] WRITE   = 4'b0100;
  localparam logic [3:0] CONSUME = 4'b1000;

  // READ and CONSUME return data and therefore occupy an ID FIFO slot.
  function automatic logic is_data_req(input logic [3:0] req_type);
    return (req_type == READ) || (req_type == CONSUME);
  endfunction

  function automatic logic is_onehot4(input logic [3:0] req_type);
    return (req_type == FETCH) || (req_type == READ) ||
           (req_type == WRITE) || (req_type == CONSUME);
  endfunction

endpackage

// File: rtl/fiber_id_fifo.sv
// In-order FIFO of requester IDs for outstanding data-returning requests.
// Push and pop in the same cycle are both honoured; count stays unchanged.
module fiber_id_fifo #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_id,
  input  logic                     pop,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full,
  output logic [WIDTH-1:0]         head
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_COUNT);
  assign head    = mem[rd_ptr];
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_id;
    end
  end

  // Pointer and occupancy tracking.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fiber_pe_arbiter.sv
// Round-robin merge of PE request streams onto one fiberBank request port,
// with an in-order ID FIFO that steers bank read data back to its owner.
module fiber_pe_arbiter
  import fiber_pkg::*;
#(
  parameter int NUM_PE     = 4,
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 64,
  parameter int TAG_DEPTH  = 8
) (
  input  logic                           i_clk,
  input  logic                           i_reset,
  input  logic [NUM_PE*4-1:0]            i_pe_req_type,
  input  logic [NUM_PE*ADDR_WIDTH-1:0]   i_pe_addr,
  input  logic [NUM_PE*DATA_WIDTH-1:0]   i_pe_data,
  input  logic [NUM_PE-1:0]              i_pe_valid,
  output logic [NUM_PE-1:0]              o_pe_ready,
  output logic [DATA_WIDTH-1:0]          o_pe_rdata,
  output logic [NUM_PE-1:0]              o_pe_rdata_valid,
  input  logic [NUM_PE-1:0]              i_pe_rdata_ready,
  output logic [3:0]                     o_request_type,
  output logic [ADDR_WIDTH-1:0]          o_addr,
  output logic [DATA_WIDTH-1:0]          o_data,
  output logic                           o_type_valid,
  input  logic                           i_type_ready,
  input  logic [DATA_WIDTH-1:0]          i_pe_data_o,
  input  logic                           i_pe_data_o_valid,
  output logic                           o_pe_data_o_ready,
  output logic                           o_err_bad_type,
  output logic                           o_err_orphan
);

  localparam int PW = $clog2(NUM_PE);
  localparam int CW = $clog2(TAG_DEPTH) + 1;
  localparam logic [CW-1:0] CREDIT_MAX = CW'(TAG_DEPTH);

  logic [3:0]            pe_type [NUM_PE];
  logic [ADDR_WIDTH-1:0] pe_addr [NUM_PE];
  logic [DATA_WIDTH-1:0] pe_data [NUM_PE];
  logic [NUM_PE-1:0]     eligible;

  logic                  reg_valid;
  logic [3:0]            reg_type;
  logic [ADDR_WIDTH-1:0] reg_addr;
  logic [DATA_WIDTH-1:0] reg_data;
  logic [PW-1:0]         reg_owner;
  logic [PW-1:0]         rr;
  logic                  err_bad;
  logic                  err_orphan;

  logic [CW-1:0]         fifo_count;
  logic                  fifo_empty;
  logic                  fifo_full;
  logic [PW-1:0]         fifo_head;

  logic [CW-1:0]         credits;
  logic                  credit_ok;
  logic                  load_en;
  logic                  bank_hs;
  logic                  id_push;
  logic                  id_pop;
  logic                  grant_found;
  logic [PW-1:0]         grant_idx;
  logic [PW-1:0]         rr_next;
  logic [3:0]            grant_type;
  logic                  grant_good;

  // A held data request already owns a tag even though it is not in the FIFO yet.
  assign credits   = fifo_count + {{(CW-1){1'b0}}, reg_valid & is_data_req(reg_type)};
  assign credit_ok = !fifo_full && (credits < CREDIT_MAX);
  assign load_en   = !reg_valid || i_type_ready;
  assign bank_hs   = reg_valid & i_type_ready;
  assign id_push   = bank_hs & is_data_req(reg_type);

  // Unpack the flattened PE buses and mark which requests may compete.
  always_comb begin
    for (int p = 0; p < NUM_PE; p++) begin
      pe_type[p]  = i_pe_req_type[p*4 +: 4];
      pe_addr[p]  = i_pe_addr[p*ADDR_WIDTH +: ADDR_WIDTH];
      pe_data[p]  = i_pe_data[p*DATA_WIDTH +: DATA_WIDTH];
      eligible[p] = !is_data_req(pe_type[p]) || credit_ok;
    end
  end

  // Round-robin search from rr; blocked PEs are skipped, and no grant is made
  // while the output register is stalled.
  always_comb begin
    int idx;
    idx         = 0;
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = 0; k < NUM_PE; k++) begin
      idx = (int'(rr) + k) % NUM_PE;
      if (!grant_found && load_en && i_pe_valid[idx] && eligible[idx]) begin
        grant_found = 1'b1;
        grant_idx   = PW'(idx);
      end
    end
  end

  assign rr_next    = (grant_idx == PW'(NUM_PE - 1)) ? '0 : grant_idx + 1'b1;
  assign grant_type = pe_type[grant_idx];
  assign grant_good = is_onehot4(grant_type);
  assign o_pe_ready = (grant_found && !i_reset) ? (NUM_PE'(1) << grant_idx) : '0;

  // Output register stage, round-robin pointer and sticky error flags.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      reg_valid  <= 1'b0;
      reg_type   <= '0;
      reg_addr   <= '0;
      reg_data   <= '0;
      reg_owner  <= '0;
      rr         <= '0;
      err_bad    <= 1'b0;
      err_orphan <= 1'b0;
    end else begin
      if (grant_found) begin
        rr <= rr_next;
      end
      if (grant_found && grant_good) begin
        reg_valid <= 1'b1;
        reg_type  <= grant_type;
        reg_addr  <= pe_addr[grant_idx];
        reg_data  <= pe_data[grant_idx];
        reg_owner <= grant_idx;
      end else if (bank_hs) begin
        reg_valid <= 1'b0;
      end
      if (grant_found && !grant_good) begin
        err_bad <= 1'b1;
      end
      if (i_pe_data_o_valid && fifo_empty) begin
        err_orphan <= 1'b1;
      end
    end
  end

  assign o_type_valid   = reg_valid;
  assign o_request_type = reg_type;
  assign o_addr         = reg_addr;
  assign o_data         = reg_data;
  assign o_err_bad_type = err_bad;
  assign o_err_orphan   = err_orphan;

  // Responses pass straight through to the FIFO-head owner; with nothing
  // outstanding the bank data is accepted and dropped.
  assign o_pe_rdata        = i_pe_data_o;
  assign o_pe_rdata_valid  = (i_pe_data_o_valid && !fifo_empty) ? (NUM_PE'(1) << fifo_head) : '0;
  assign o_pe_data_o_ready = fifo_empty ? i_pe_data_o_valid : i_pe_rdata_ready[fifo_head];
  assign id_pop            = i_pe_data_o_valid & !fifo_empty & i_pe_rdata_ready[fifo_head];

  fiber_id_fifo #(
    .WIDTH (PW),
    .DEPTH (TAG_DEPTH)
  ) u_id_fifo (
    .clk     (i_clk),
    .reset   (i_reset),
    .push    (id_push),
    .push_id (reg_owner),
    .pop     (id_pop),
    .count   (fifo_count),
    .empty   (fifo_empty),
    .full    (fifo_full),
    .head    (fifo_head)
  );

endmodule

// File: tb/tb_fiber_pe_arbiter.sv
// Bench for fiber_pe_arbiter: a transaction-level model (queue of owner IDs,
// one held-request record) checked every cycle, plus directed scenarios.
module tb_fiber_pe_arbiter;

  localparam int NUM_PE     = 4;
  localparam int DATA_WIDTH = 16;
  localparam int ADDR_WIDTH = 64;
  localparam int TAG_DEPTH  = 8;

  logic                         i_clk = 1'b0;
  logic                         i_reset;
  logic [NUM_PE*4-1:0]          i_pe_req_type;
  logic [NUM_PE*ADDR_WIDTH-1:0] i_pe_addr;
  logic [NUM_PE*DATA_WIDTH-1:0] i_pe_data;
  logic [NUM_PE-1:0]            i_pe_valid;
  logic [NUM_PE-1:0]            o_pe_ready;
  logic [DATA_WIDTH-1:0]        o_pe_rdata;
  logic [NUM_PE-1:0]            o_pe_rdata_valid;
  logic [NUM_PE-1:0]            i_pe_rdata_ready;
  logic [3:0]                   o_request_type;
  logic [ADDR_WIDTH-1:0]        o_addr;
  logic [DATA_WIDTH-1:0]        o_data;
  logic                         o_type_valid;
  logic                         i_type_ready;
  logic [DATA_WIDTH-1:0]        i_pe_data_o;
  logic                         i_pe_data_o_valid;
  logic                         o_pe_data_o_ready;
  logic                         o_err_bad_type;
  logic                         o_err_orphan;

  always #5 i_clk = ~i_clk;

  fiber_pe_arbiter #(
    .NUM_PE(NUM_PE), .DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .TAG_DEPTH(TAG_DEPTH)
  ) dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_pe_req_type(i_pe_req_type), .i_pe_addr(i_pe_addr), .i_pe_data(i_pe_data),
    .i_pe_valid(i_pe_valid), .o_pe_ready(o_pe_ready),
    .o_pe_rdata(o_pe_rdata), .o_pe_rdata_valid(o_pe_rdata_valid), .i_pe_rdata_ready(i_pe_rdata_ready),
    .o_request_type(o_request_type), .o_addr(o_addr), .o_data(o_data),
    .o_type_valid(o_type_valid), .i_type_ready(i_type_ready),
    .i_pe_data_o(i_pe_data_o), .i_pe_data_o_valid(i_pe_data_o_valid), .o_pe_data_o_ready(o_pe_data_o_ready),
    .o_err_bad_type(o_err_bad_type), .o_err_orphan(o_err_orphan)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  bit              m_valid;
  logic [3:0]      m_type;
  logic [63:0]     m_addr;
  logic [15:0]     m_data;
  int              m_owner;
  int              m_rr;
  int              idq[$];
  bit              m_bad;
  bit              m_orphan;
  int              grant_log[$];
  logic [63:0]     bank_log[$];

  int              c_credits;
  int              c_win;
  logic [3:0]      c_exp_ready;
  logic [3:0]      c_exp_rv;
  logic            c_exp_dr;

  function automatic bit is_data(input logic [3:0] t);
    return (t == 4'b0010) || (t == 4'b1000);
  endfunction

  function automatic logic [3:0] req_of(input int p);
    return i_pe_req_type[p*4 +: 4];
  endfunction

  always @(negedge i_clk) begin
    if (i_reset) begin
      m_valid = 0; m_type = 0; m_addr = 0; m_data = 0; m_owner = 0;
      m_rr = 0; idq.delete(); m_bad = 0; m_orphan = 0;
    end else begin
      check("type_valid", o_type_valid, m_valid);
      if (m_valid) begin
        check("request_type", o_request_type, m_type);
        check("addr", o_addr, m_addr);
        check("data", o_data, m_data);
      end
      check("err_bad_type", o_err_bad_type, m_bad);
      check("err_orphan", o_err_orphan, m_orphan);

      c_credits = idq.size() + ((m_valid && is_data(m_type)) ? 1 : 0);
      c_win = -1;
      if (!m_valid || i_type_ready) begin
        for (int k = 0; k < NUM_PE; k++) begin
          int p;
          p = (m_rr + k) % NUM_PE;
          if (c_win < 0 && i_pe_valid[p] && (!is_data(req_of(p)) || c_credits < TAG_DEPTH))
            c_win = p;
        end
      end
      c_exp_ready = (c_win < 0) ? 4'b0 : 4'(1 << c_win);
      check("pe_ready", o_pe_ready, c_exp_ready);

      if (idq.size() == 0) begin
        c_exp_rv = 4'b0;
        c_exp_dr = i_pe_data_o_valid;
      end else begin
        c_exp_rv = i_pe_data_o_valid ? 4'(1 << idq[0]) : 4'b0;
        c_exp_dr = i_pe_rdata_ready[idq[0]];
      end
      check("rdata_valid", o_pe_rdata_valid, c_exp_rv);
      check("data_o_ready", o_pe_data_o_ready, c_exp_dr);
      check("rdata", o_pe_rdata, i_pe_data_o);

      if (c_win >= 0) grant_log.push_back(c_win);
      if (m_valid && i_type_ready) bank_log.push_back(m_addr);

      if (i_pe_data_o_valid && idq.size() == 0) m_orphan = 1;
      else if (i_pe_data_o_valid && c_exp_dr) void'(idq.pop_front());
      if (m_valid && i_type_ready) begin
        if (is_data(m_type)) idq.push_back(m_owner);
        m_valid = 0;
      end
      if (c_win >= 0) begin
        m_rr = (c_win + 1) % NUM_PE;
        if ($countones(req_of(c_win)) == 1) begin
          m_valid = 1;
          m_type  = req_of(c_win);
          m_addr  = i_pe_addr[c_win*ADDR_WIDTH +: ADDR_WIDTH];
          m_data  = i_pe_data[c_win*DATA_WIDTH +: DATA_WIDTH];
          m_owner = c_win;
        end else begin
          m_bad = 1;
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  task automatic idle();
    i_pe_valid = '0;
    i_pe_req_type = '0;
    i_pe_addr = '0;
    i_pe_data = '0;
    i_type_ready = 1'b1;
    i_pe_data_o_valid = 1'b0;
    i_pe_data_o = '0;
    i_pe_rdata_ready = '1;
  endtask

  task automatic set_req(input int p, input logic [3:0] t, input logic [63:0] a, input logic [15:0] d);
    i_pe_req_type[p*4 +: 4] = t;
    i_pe_addr[p*ADDR_WIDTH +: ADDR_WIDTH] = a;
    i_pe_data[p*DATA_WIDTH +: DATA_WIDTH] = d;
    i_pe_valid[p] = 1'b1;
  endtask

  task automatic flush();
    int n;
    n = 0;
    i_pe_valid = '0;
    i_type_ready = 1'b1;
    i_pe_rdata_ready = '1;
    while ((idq.size() > 0 || m_valid) && n < 64) begin
      i_pe_data_o_valid = (idq.size() > 0);
      i_pe_data_o = 16'($urandom);
      cyc(1);
      n++;
    end
    i_pe_data_o_valid = 1'b0;
    if (n >= 64) begin
      n_checks++;
      $display("FAIL flush_timeout: outstanding %0d required 0", idq.size());
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  int exp_g[5] = '{0, 1, 2, 3, 0};
  logic [63:0] exp_a[5] = '{64'h1000, 64'h1001, 64'h1002, 64'h1003, 64'h1000};

  initial begin
    i_reset = 1'b1;
    idle();
    cyc(3);
    i_reset = 1'b0;
    #1;
    check("rst_type_valid", o_type_valid, 0);
    check("rst_request_type", o_request_type, 0);
    check("rst_addr", o_addr, 0);
    check("rst_data", o_data, 0);
    check("rst_err_bad", o_err_bad_type, 0);
    check("rst_err_orphan", o_err_orphan, 0);
    check("rst_rdata_valid", o_pe_rdata_valid, 0);
    cyc(1);

    // round-robin fairness
    grant_log.delete(); bank_log.delete();
    for (int p = 0; p < NUM_PE; p++) set_req(p, 4'b0010, 64'h1000 + 64'(p), 16'(p));
    cyc(5);
    i_pe_valid = '0;
    cyc(2);
    check("rr_grant_count", grant_log.size(), 5);
    check("rr_bank_count", bank_log.size(), 5);
    for (int i = 0; i < 5; i++) begin
      if (i < grant_log.size()) check("rr_grant_order", grant_log[i], exp_g[i]);
      if (i < bank_log.size()) check("rr_bank_addr", bank_log[i], exp_a[i]);
    end
    flush();

    // backpressure
    idle();
    grant_log.delete(); bank_log.delete();
    i_type_ready = 1'b0;
    set_req(1, 4'b0100, 64'hFFFFFFFF, 16'h0000);
    cyc(3);
    check("bp_hold_valid", o_type_valid, 1);
    check("bp_hold_addr", o_addr, 64'hFFFFFFFF);
    check("bp_no_ready", o_pe_ready, 0);
    cyc(3);
    i_pe_valid = '0;
    i_type_ready = 1'b1;
    cyc(3);
    check("bp_grants", grant_log.size(), 1);
    check("bp_handshakes", bank_log.size(), 1);
    if (bank_log.size() > 0) check("bp_bank_addr", bank_log[0], 64'hFFFFFFFF);

    // response routing
    idle();
    set_req(2, 4'b0010, 64'h22, 16'h0);
    cyc(1);
    i_pe_valid = '0;
    set_req(0, 4'b1000, 64'h33, 16'h0);
    cyc(1);
    i_pe_valid = '0;
    cyc(2);
    i_pe_data_o_valid = 1'b1;
    i_pe_data_o = 16'hAAAA;
    i_pe_rdata_ready = 4'b1011;
    #1;
    check("resp_stall_valid", o_pe_rdata_valid, 4'b0100);
    check("resp_stall_ready", o_pe_data_o_ready, 0);
    cyc(1);
    i_pe_rdata_ready = 4'b1111;
    #1;
    check("resp_first_ready", o_pe_data_o_ready, 1);
    check("resp_first_data", o_pe_rdata, 16'hAAAA);
    cyc(1);
    i_pe_data_o = 16'h5555;
    #1;
    check("resp_second_valid", o_pe_rdata_valid, 4'b0001);
    check("resp_second_data", o_pe_rdata, 16'h5555);
    cyc(1);
    i_pe_data_o_valid = 1'b0;
    flush();

    // credit limit
    idle();
    grant_log.delete();
    set_req(0, 4'b0010, 64'h40, 16'h0);
    cyc(10);
    check("credit_read_grants", grant_log.size(), TAG_DEPTH);
    set_req(1, 4'b0001, 64'h41, 16'h0);
    #1;
    check("credit_fetch_grant", o_pe_ready, 4'b0010);
    cyc(1);
    i_pe_valid[1] = 1'b0;
    i_pe_data_o_valid = 1'b1;
    i_pe_data_o = 16'h1234;
    #1;
    check("credit_pop_cycle_ready", o_pe_ready, 4'b0000);
    check("credit_pop_accept", o_pe_data_o_ready, 1);
    cyc(1);
    i_pe_data_o_valid = 1'b0;
    #1;
    check("credit_ninth_grant", o_pe_ready, 4'b0001);
    cyc(1);
    flush();

    // errors
    idle();
    set_req(3, 4'b0011, 64'h77, 16'h0);
    #1;
    check("bad_type_ready", o_pe_ready, 4'b1000);
    cyc(1);
    i_pe_valid = '0;
    #1;
    check("bad_type_not_fwd", o_type_valid, 0);
    check("bad_type_flag", o_err_bad_type, 1);
    i_pe_data_o_valid = 1'b1;
    i_pe_data_o = 16'hBEEF;
    #1;
    check("orphan_accept", o_pe_data_o_ready, 1);
    check("orphan_no_route", o_pe_rdata_valid, 0);
    cyc(1);
    i_pe_data_o_valid = 1'b0;
    cyc(4);
    check("bad_type_sticky", o_err_bad_type, 1);
    check("orphan_sticky", o_err_orphan, 1);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      for (int p = 0; p < NUM_PE; p++) begin
        logic [3:0] t;
        if ($urandom_range(0, 15) == 0) t = 4'($urandom_range(0, 15));
        else t = 4'(1 << $urandom_range(0, 3));
        i_pe_req_type[p*4 +: 4] = t;
        i_pe_addr[p*ADDR_WIDTH +: ADDR_WIDTH] = {$urandom, $urandom};
        i_pe_data[p*DATA_WIDTH +: DATA_WIDTH] = 16'($urandom);
        i_pe_valid[p] = 1'($urandom_range(0, 1));
      end
      i_type_ready = ($urandom_range(0, 3) != 0);
      i_pe_data_o_valid = ($urandom_range(0, 2) == 0);
      i_pe_data_o = 16'($urandom);
      i_pe_rdata_ready = 4'($urandom_range(0, 15) | $urandom_range(0, 15));
      cyc(1);
    end

    // reset mid-operation
    idle();
    set_req(0, 4'b0010, 64'h90, 16'h0);
    cyc(3);
    i_pe_valid = '0;
    cyc(1);
    i_type_ready = 1'b0;
    set_req(1, 4'b0100, 64'h91, 16'h5A5A);
    cyc(1);
    i_pe_valid = '0;
    check("pre_reset_held", o_type_valid, 1);
    i_reset = 1'b1;
    cyc(1);
    i_reset = 1'b0;
    i_pe_data_o_valid = 1'b1;
    #1;
    check("mid_rst_type_valid", o_type_valid, 0);
    check("mid_rst_request_type", o_request_type, 0);
    check("mid_rst_addr", o_addr, 0);
    check("mid_rst_data", o_data, 0);
    check("mid_rst_err_bad", o_err_bad_type, 0);
    check("mid_rst_err_orphan", o_err_orphan, 0);
    check("mid_rst_fifo_empty_route", o_pe_rdata_valid, 0);
    check("mid_rst_fifo_empty_ready", o_pe_data_o_ready, 1);
    cyc(1);
    i_pe_data_o_valid = 1'b0;
    cyc(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
